// File: rtl/demux_pkg.sv
// Shared constants and FSM encoding for the 1:4 round-robin demux scheduler.
package demux_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2
    } state_t;

    // One-hot decode of a channel select.
    function automatic logic [NCH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NCH-1:0] oh;
        oh      = {NCH{1'b0}};
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_rr_ctrl_rr_pick.sv
// Rotating-priority find-first-set: first eligible channel after 'last', wrapping mod 4.
module rr_pick
    import demux_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] nxt,
    output logic             any
);

    logic [SEL_W-1:0] idx_s;

    // Scan from the farthest offset down so the nearest eligible channel wins.
    always_comb begin
        nxt   = last;
        idx_s = {SEL_W{1'b0}};
        for (int off = NCH; off >= 1; off--) begin
            idx_s = last + SEL_W'(off);
            nxt   = mask[idx_s] ? idx_s : nxt;
        end
        any = |mask;
    end

endmodule

// File: rtl/demux_rr_ctrl.sv
// Round-robin burst scheduler sharing one valid/ready stream across four consumers.
module demux_rr_ctrl
    import demux_pkg::*;
#(
    parameter int DW    = 8,
    parameter int BURST = 4,
    parameter int TMO   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NCH-1:0]   mask,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DW-1:0]    out_data,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready,
    output logic [SEL_W-1:0] s,
    output logic             busy
);

    localparam int BW = $clog2(BURST + 1);
    localparam int TW = $clog2(TMO + 2);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'((TMO > 0) ? (TMO - 1) : 0);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [SEL_W-1:0] s_r;
    logic [SEL_W-1:0] last_r;
    logic [BW-1:0]    beat_cnt_r;
    logic [TW-1:0]    tmo_cnt_r;
    logic             busy_r;
    logic             granted_s;
    logic             xfer_s;
    logic             burst_done_s;
    logic             tmo_hit_s;
    logic [SEL_W-1:0] pick_nxt_s;
    logic             pick_any_s;

    rr_pick u_rr_pick (
        .mask (mask),
        .last (last_r),
        .nxt  (pick_nxt_s),
        .any  (pick_any_s)
    );

    // State register and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == GRANT);
        end
    end

    // Next-state logic; a dropped grant outranks burst completion, which outranks timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = (en && pick_any_s) ? ARB : IDLE;
            ARB:     state_nxt_s = (en && pick_any_s) ? GRANT : IDLE;
            GRANT: begin
                if (!granted_s) begin
                    state_nxt_s = IDLE;
                end else if (burst_done_s || tmo_hit_s) begin
                    state_nxt_s = ARB;
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output gating; en and mask[s] act in the same cycle so no beat slips through.
    always_comb begin
        granted_s    = (state_r == GRANT) && en && mask[s_r];
        xfer_s       = in_valid && out_ready[s_r] && granted_s;
        burst_done_s = xfer_s && (beat_cnt_r == BEAT_LAST);
        tmo_hit_s    = (TMO != 0) && !xfer_s && (tmo_cnt_r == TMO_LAST);
        in_ready     = out_ready[s_r] && granted_s;
        out_valid    = sel_onehot(s_r) & {NCH{in_valid && granted_s}};
        out_data     = in_data;
        s            = s_r;
        busy         = busy_r;
    end

    // Select, last-served channel and beat/idle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r        <= {SEL_W{1'b0}};
            last_r     <= 2'd3;
            beat_cnt_r <= {BW{1'b0}};
            tmo_cnt_r  <= {TW{1'b0}};
        end else begin
            case (state_r)
                ARB: begin
                    beat_cnt_r <= {BW{1'b0}};
                    tmo_cnt_r  <= {TW{1'b0}};
                    if (state_nxt_s == GRANT) begin
                        s_r <= pick_nxt_s;
                    end else begin
                        s_r <= s_r;
                    end
                end
                GRANT: begin
                    if (state_nxt_s != GRANT) begin
                        last_r <= s_r;
                    end else begin
                        last_r <= last_r;
                    end
                    if (xfer_s) begin
                        beat_cnt_r <= beat_cnt_r + BW'(1);
                        tmo_cnt_r  <= {TW{1'b0}};
                    end else begin
                        tmo_cnt_r  <= tmo_cnt_r + TW'(1);
                    end
                end
                default: begin
                    s_r <= s_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_rr_ctrl.sv
// Directed bench for demux_rr_ctrl: vector table for rotation, hand sequences for corner cases.
module tb_demux_rr_ctrl;
    import demux_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [3:0]       mask;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [1:0]       s;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] mask;
        logic       vld;
        logic [3:0] rdy;
        logic [1:0] es;
        logic       eb;
        logic       eir;
        logic [3:0] eov;
    } vec_t;

    vec_t vecs[$];

    demux_rr_ctrl #(.DW(8), .BURST(4), .TMO(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mask      (mask),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] es, input logic eb,
                         input logic eir, input logic [3:0] eov);
        n_tests++;
        if (s !== es || busy !== eb || in_ready !== eir || out_valid !== eov || out_data !== in_data) begin
            n_fail++;
            $display("FAIL %s: got s=%0d busy=%b in_ready=%b out_valid=%b out_data=%h, want s=%0d busy=%b in_ready=%b out_valid=%b out_data=%h",
                     name, s, busy, in_ready, out_valid, out_data, es, eb, eir, eov, in_data);
        end
    endtask

    task automatic drive(input logic e, input logic [3:0] m, input logic v, input logic [3:0] r);
        en        = e;
        mask      = m;
        in_valid  = v;
        out_ready = r;
        in_data   = 8'($urandom);
    endtask

    // Check at the falling edge, then advance to just after the next rising edge.
    task automatic cyc(input string name, input logic [1:0] es, input logic eb,
                       input logic eir, input logic [3:0] eov);
        @(negedge clk);
        check(name, es, eb, eir, eov);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 4'b1111, 1'b1, 4'b1111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 2'd0, 1'b0, 1'b0, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic add(input logic r, input logic e, input logic [3:0] m, input logic v,
                       input logic [3:0] rd, input logic [1:0] es, input logic eb,
                       input logic eir, input logic [3:0] eov);
        vec_t x;
        x.rst = r; x.en = e; x.mask = m; x.vld = v; x.rdy = rd;
        x.es = es; x.eb = eb; x.eir = eir; x.eov = eov;
        vecs.push_back(x);
    endtask

    initial begin
        logic [1:0] ch;
        rst_n = 1'b0;
        drive(1'b0, 4'b0000, 1'b0, 4'b0000);

        // Full mask: ch0,1,2,3,0, four beats each, one ARB bubble between.
        add(1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 4'b0000);
        add(1'b0, 1'b1, 4'b1111, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 4'b0000);
        for (int g = 0; g < 5; g++) begin
            ch = 2'(g);
            for (int b = 0; b < 4; b++)
                add(1'b0, 1'b1, 4'b1111, 1'b1, 4'b1111, ch, 1'b1, 1'b1, 4'b0001 << ch);
            add(1'b0, 1'b1, 4'b1111, 1'b1, 4'b1111, ch, 1'b0, 1'b0, 4'b0000);
        end
        // Mask 0101: alternate ch0 and ch2 only.
        add(1'b1, 1'b1, 4'b0101, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 4'b0000);
        add(1'b0, 1'b1, 4'b0101, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 4'b0000);
        for (int g = 0; g < 4; g++) begin
            ch = (g % 2 == 0) ? 2'd0 : 2'd2;
            for (int b = 0; b < 4; b++)
                add(1'b0, 1'b1, 4'b0101, 1'b1, 4'b1111, ch, 1'b1, 1'b1, 4'b0001 << ch);
            add(1'b0, 1'b1, 4'b0101, 1'b1, 4'b1111, ch, 1'b0, 1'b0, 4'b0000);
        end

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].en, vecs[i].mask, vecs[i].vld, vecs[i].rdy);
            cyc($sformatf("vec%0d", i), vecs[i].es, vecs[i].eb, vecs[i].eir, vecs[i].eov);
        end

        // Timeout: ch1 stalled 16 cycles, then released, next grant ch2.
        do_reset();
        drive(1'b1, 4'b0010, 1'b1, 4'b1101);
        cyc("tmo_idle", 2'd0, 1'b0, 1'b0, 4'b0000);
        cyc("tmo_arb", 2'd0, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'b0110, 1'b1, 4'b1101);
            cyc($sformatf("tmo_stall%0d", i), 2'd1, 1'b1, 1'b0, 4'b0010);
        end
        drive(1'b1, 4'b0110, 1'b1, 4'b1101);
        cyc("tmo_rel_arb", 2'd1, 1'b0, 1'b0, 4'b0000);
        cyc("tmo_next_ch2", 2'd2, 1'b1, 1'b1, 4'b0100);

        // mask[2] dropped after two beats on ch2.
        do_reset();
        drive(1'b1, 4'b0100, 1'b1, 4'b1111);
        cyc("mdrop_idle", 2'd0, 1'b0, 1'b0, 4'b0000);
        cyc("mdrop_arb", 2'd0, 1'b0, 1'b0, 4'b0000);
        cyc("mdrop_b1", 2'd2, 1'b1, 1'b1, 4'b0100);
        cyc("mdrop_b2", 2'd2, 1'b1, 1'b1, 4'b0100);
        drive(1'b1, 4'b1000, 1'b1, 4'b1111);
        cyc("mdrop_gate", 2'd2, 1'b1, 1'b0, 4'b0000);
        cyc("mdrop_idle2", 2'd2, 1'b0, 1'b0, 4'b0000);
        cyc("mdrop_arb2", 2'd2, 1'b0, 1'b0, 4'b0000);
        cyc("mdrop_ch3", 2'd3, 1'b1, 1'b1, 4'b1000);

        // Asynchronous reset during beat 3 of ch1.
        do_reset();
        drive(1'b1, 4'b0010, 1'b1, 4'b1111);
        cyc("arst_idle", 2'd0, 1'b0, 1'b0, 4'b0000);
        cyc("arst_arb", 2'd0, 1'b0, 1'b0, 4'b0000);
        cyc("arst_b1", 2'd1, 1'b1, 1'b1, 4'b0010);
        cyc("arst_b2", 2'd1, 1'b1, 1'b1, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_async", 2'd0, 1'b0, 1'b0, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 4'b1111, 1'b1, 4'b1111);
        cyc("arst_idle2", 2'd0, 1'b0, 1'b0, 4'b0000);
        cyc("arst_arb2", 2'd0, 1'b0, 1'b0, 4'b0000);
        cyc("arst_ch0", 2'd0, 1'b1, 1'b1, 4'b0001);

        // Empty mask keeps the block idle.
        do_reset();
        drive(1'b1, 4'b0000, 1'b1, 4'b1111);
        for (int i = 0; i < 22; i++)
            cyc($sformatf("mask0_%0d", i), 2'd0, 1'b0, 1'b0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
